// File: rtl/slice_input_scheduler.sv
// slice_input_scheduler
//   Flow-control sequencer in front of the slice demultiplexer. The word data
//   itself bypasses this block. This block decides when a word may enter the
//   demux, and it drives the demux valid, sof and pps controls.
//
//   Each per-slice rate buffer has a credit counter. The counter starts full
//   and is debited exactly as the demux writes that buffer. A word is held off
//   while the buffers it would land in have no space. Chunk and row tracking
//   detect the last word of a frame. The block then drains until every credit
//   has come back, and only after that does it release the next frame.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous abort: back to IDLE, all credits restored
//   slices_per_line   slices per line, 1..MAX_NBR_SLICES
//   chunk_size        bytes per chunk (>=32)
//   chunk_rows        chunk rows per frame (>=1)
//   in_valid, in_sof  upstream word strobe and first-word-of-frame flag
//   in_ready          word accepted when in_valid & in_ready
//   credit_return     bit s: one word left rate buffer s this cycle
//   dm_valid, dm_sof  accepted-word strobe and sof to the demux
//   dm_is_pps         current word belongs to the PPS header
//   cur_slice         slice the current word is written to
//   frame_done        one-cycle pulse once a frame has fully drained
module slice_input_scheduler #(
  parameter int MAX_NBR_SLICES   = 2,
  parameter int FIFO_DEPTH_WORDS = 64,
  parameter int PPS_WORDS        = 4
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              flush,
  input  logic [9:0]                                        slices_per_line,
  input  logic [15:0]                                       chunk_size,
  input  logic [15:0]                                       chunk_rows,
  input  logic                                              in_valid,
  input  logic                                              in_sof,
  output logic                                              in_ready,
  input  logic [MAX_NBR_SLICES-1:0]                         credit_return,
  output logic                                              dm_valid,
  output logic                                              dm_sof,
  output logic                                              dm_is_pps,
  output logic [(MAX_NBR_SLICES>1?$clog2(MAX_NBR_SLICES):1)-1:0] cur_slice,
  output logic                                              frame_done
);

  localparam int SW = (MAX_NBR_SLICES > 1) ? $clog2(MAX_NBR_SLICES) : 1;
  localparam int CW = $clog2(FIFO_DEPTH_WORDS + 1);
  localparam int PW = (PPS_WORDS > 1) ? $clog2(PPS_WORDS + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_PPS, S_DATA, S_DRAIN, S_ERR} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   pps_cnt;
  logic [15:0]     byte_cnt;
  logic [4:0]      byte_offset;
  logic [15:0]     row;
  logic [CW-1:0]   credit [MAX_NBR_SLICES];
  logic [1:0]      debit  [MAX_NBR_SLICES];

  logic [16:0]     sum_cnt;
  logic            last_word;
  logic [4:0]      rem5;
  logic [4:0]      off_sum;
  logic            aligned;
  logic            dbl;
  logic [9:0]      cur_ext;
  logic            wrap;
  logic [SW-1:0]   nxt;
  logic            data_ok;
  logic            eof;
  logic            accept;
  logic            all_full;
  logic            sof_err;

  // Clamp a credit value into 0..FIFO_DEPTH_WORDS.
  function automatic logic [CW-1:0] sat_credit(input logic signed [CW+2:0] v);
    if (v < 0)
      return '0;
    else if (v > $signed((CW+3)'(FIFO_DEPTH_WORDS)))
      return CW'(FIFO_DEPTH_WORDS);
    else
      return v[CW-1:0];
  endfunction

  // Chunk tracking for the word presented in DATA. Only the low 5 bits of the
  // overhang past the chunk end matter, because the offset is kept mod 32.
  always_comb begin
    sum_cnt   = {1'b0, byte_cnt} + 17'd32;
    last_word = sum_cnt > {1'b0, chunk_size};
    rem5      = byte_cnt[4:0] - chunk_size[4:0];
    off_sum   = byte_offset + rem5;
    aligned   = (off_sum == 5'd0);
    dbl       = last_word && aligned;
    cur_ext   = 10'(cur_slice);
    wrap      = (cur_ext + 10'd1) >= slices_per_line;
    nxt       = wrap ? '0 : cur_slice + SW'(1);
    eof       = last_word && wrap && (row == (chunk_rows - 16'd1));
  end

  // An aligned chunk end also writes the next slice. When that slice is the
  // current slice, the word needs two credits from the same buffer.
  always_comb begin
    if (dbl && (nxt == cur_slice))
      data_ok = {1'b0, credit[cur_slice]} >= (CW+1)'(2);
    else
      data_ok = (credit[cur_slice] >= CW'(1)) &&
                (!dbl || (credit[nxt] >= CW'(1)));
  end

  always_comb begin
    all_full = 1'b1;
    for (int s = 0; s < MAX_NBR_SLICES; s++)
      if (credit[s] != CW'(FIFO_DEPTH_WORDS))
        all_full = 1'b0;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    dm_is_pps = 1'b0;
    sof_err   = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready  = in_sof;
        dm_is_pps = in_sof;
        if (in_valid && in_sof)
          state_n = (PPS_WORDS == 1) ? S_DATA : S_PPS;
      end
      S_PPS: begin
        in_ready  = !in_sof;
        dm_is_pps = 1'b1;
        if (in_valid && in_sof)
          sof_err = 1'b1;
        else if (in_valid && (pps_cnt == PW'(PPS_WORDS - 1)))
          state_n = S_DATA;
      end
      S_DATA: begin
        in_ready = !in_sof && data_ok;
        if (in_valid && in_sof)
          sof_err = 1'b1;
        else if (in_valid && in_ready && eof)
          state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (in_valid && in_sof)
          sof_err = 1'b1;
        else if (all_full)
          state_n = S_IDLE;
      end
      S_ERR:   state_n = S_ERR;
      default: state_n = S_IDLE;
    endcase
    if (sof_err)
      state_n = S_ERR;
  end

  assign accept   = in_valid && in_ready;
  assign dm_valid = accept;
  assign dm_sof   = accept && in_sof;

  always_comb begin
    for (int s = 0; s < MAX_NBR_SLICES; s++) begin
      debit[s] = 2'd0;
      if (accept && (state == S_DATA))
        debit[s] = {1'b0, (cur_slice == SW'(s))} + {1'b0, dbl && (nxt == SW'(s))};
    end
  end

  // Control state, frame counters and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pps_cnt     <= '0;
      byte_cnt    <= '0;
      byte_offset <= '0;
      cur_slice   <= '0;
      row         <= '0;
      frame_done  <= 1'b0;
    end else if (flush) begin
      state       <= S_IDLE;
      pps_cnt     <= '0;
      byte_cnt    <= '0;
      byte_offset <= '0;
      cur_slice   <= '0;
      row         <= '0;
      frame_done  <= 1'b0;
    end else begin
      state      <= state_n;
      frame_done <= (state == S_DRAIN) && (state_n == S_IDLE);
      if (accept && (state == S_IDLE)) begin
        pps_cnt     <= PW'(1);
        byte_cnt    <= '0;
        byte_offset <= '0;
        cur_slice   <= '0;
        row         <= '0;
      end else if (accept && (state == S_PPS)) begin
        pps_cnt <= pps_cnt + PW'(1);
      end else if (accept && (state == S_DATA)) begin
        if (last_word) begin
          byte_offset <= off_sum;
          byte_cnt    <= aligned ? 16'd32 : 16'd0;
          cur_slice   <= nxt;
          if (wrap)
            row <= row + 16'd1;
        end else begin
          byte_cnt <= sum_cnt[15:0];
        end
      end
    end
  end

  // Credit counters: a debit and a return in the same cycle net out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < MAX_NBR_SLICES; s++)
        credit[s] <= CW'(FIFO_DEPTH_WORDS);
    end else if (flush) begin
      for (int s = 0; s < MAX_NBR_SLICES; s++)
        credit[s] <= CW'(FIFO_DEPTH_WORDS);
    end else begin
      for (int s = 0; s < MAX_NBR_SLICES; s++)
        credit[s] <= sat_credit($signed({3'b000, credit[s]})
                              - $signed({{(CW+1){1'b0}}, debit[s]})
                              + $signed({{(CW+2){1'b0}}, credit_return[s]}));
    end
  end

endmodule
